hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Pipeline hazard controller for the 5-stage RV32I core. It is the stall/flush counterpart to the EX-stage forwarding logic and covers the hazards forwarding cannot resolve. It tracks the instruction in EX in a registered shadow entry, detects load-use hazards against the instruction in ID, and flushes wrong-path instructions on a taken branch. It freezes the whole pipeline while the data memory has an outstanding request, and it keeps stall and flush performance counters plus a sticky memory-timeout flag.

## Interface

Parameters:
- MEM_TIMEOUT, 255: maximum number of wait cycles for a memory request before o_mem_timeout is set.

Ports:
- i_clk  in  1  core clock. Single clock domain.
- i_rst_n  in  1  synchronous, active-low reset.
- i_ID_inst  in  32  instruction in ID; rs1 = [19:15], rs2 = [24:20], rd = [11:7].
- i_ID_valid  in  1  ID holds a real instruction (not a bubble).
- i_ID_rd_wren  in  1  ID instruction writes rd.
- i_ID_is_load  in  1  ID instruction is a load.
- i_ID_uses_rs1 / i_ID_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
- i_EX_branch_taken  in  1  branch or jump in EX redirects the PC.
- i_MEM_req  in  1  load or store in MEM has an active memory request.
- i_MEM_ack  in  1  memory completes the request this cycle.
- o_PC_en, o_IF_ID_en, o_ID_EX_en, o_EX_MEM_en, o_MEM_WB_en  out  1 each  pipeline register enables.
- o_IF_ID_flush, o_ID_EX_flush  out  1 each  load a bubble into that register at the next edge.
- o_MEM_WB_bubble  out  1  MEM/WB captures a bubble (regfile write suppressed).
- o_stall_cnt  out  32  count of load-use stall cycles.
- o_flush_cnt  out  32  count of taken-branch flush events.
- o_mem_timeout  out  1  sticky flag: a memory wait exceeded MEM_TIMEOUT.

## Operation

- EX shadow entry {v, rd, ld}:
  - When o_ID_EX_en=1: loads 0 if o_ID_EX_flush, else {i_ID_valid & i_ID_rd_wren, rd, i_ID_is_load}.
  - Otherwise it holds.
- Load-use hazard (lu): all of the following hold.
  - shadow v & ld & rd != 0.
  - i_ID_valid.
  - (uses_rs1 & rs1 == rd) | (uses_rs2 & rs2 == rd).
- FSM states:
  - RUN → MEM_WAIT when i_MEM_req & !i_MEM_ack.
  - MEM_WAIT → RUN when i_MEM_ack.
  - All other cases stay in the current state.
- Freeze (fz) = i_MEM_req & !i_MEM_ack, in either state. While fz:
  - o_PC_en, o_IF_ID_en, o_ID_EX_en, o_EX_MEM_en are all 0.
  - o_MEM_WB_bubble = 1, o_MEM_WB_en = 1.
  - Both flushes are 0.
  - Counters hold.
- Priority, highest first: reset > fz > branch flush > lu stall.
- Branch (i_EX_branch_taken & !fz):
  - o_IF_ID_flush = 1, o_ID_EX_flush = 1.
  - All enables 1.
  - o_flush_cnt += 1.
  - lu is ignored in the same cycle, because the ID instruction is wrong-path.
- Load-use stall (lu & !fz & !branch):
  - o_PC_en = 0, o_IF_ID_en = 0.
  - o_ID_EX_flush = 1, so a bubble goes to EX.
  - All other enables 1.
  - o_stall_cnt += 1.
- Default (none of the above): all enables 1, flushes 0, o_MEM_WB_bubble = 0.
- Wait counter:
  - Cleared in RUN.
  - Increments each MEM_WAIT cycle, saturating at MEM_TIMEOUT.
  - Reaching MEM_TIMEOUT sets o_mem_timeout.
  - o_mem_timeout clears only on reset. The pipeline stays frozen regardless.
- Counter rules: 32-bit, wrap from 0xFFFFFFFF to 0, no saturation.

## Timing

- Reset, applied on an i_clk edge with i_rst_n=0:
  - Shadow cleared, state RUN, wait counter 0, both counters 0, o_mem_timeout 0.
  - Outputs follow the combinational rules with the cleared shadow: enables 1, flushes 0, bubble 0, unless fz.
- Reset mid-MEM_WAIT returns to RUN at the next edge; i_MEM_req is still honoured combinationally.
- Outputs are combinational from the registered shadow/state and the current inputs. Zero-cycle latency to the pipeline enables.
- Load-use:
  - Load in EX at cycle N with a matching consumer in ID gives exactly one stall cycle (N).
  - At N+1 the shadow holds the bubble and the consumer proceeds, with the MEM→EX forward covering it.
- Branch taken in EX at cycle N: the two wrong-path instructions become bubbles at edge N+1.
- Freeze of K cycles (ack in the K-th cycle):
  - Pipeline stalled for K-1 cycles.
  - Released in the ack cycle.
  - A branch that is pending in EX during the freeze is acted on in the first unfrozen cycle.
- rd = x0 never causes a stall.

## Test plan

- Load then dependent use: shadow {1, x5, ld} with ID `add x6, x5, x1` → one cycle with PC_en=0, IF_ID_en=0, ID_EX_flush=1; next cycle no stall; o_stall_cnt=1.
- Load to x0 followed by a reader of x0, and load x5 followed by an instruction with uses_rs2=0 and rs2=5 → no stall.
- Branch taken while lu is also true → both flushes 1, PC_en=1; o_flush_cnt=1, o_stall_cnt unchanged.
- i_MEM_req=1 with ack after 4 cycles → 3 frozen cycles (enables 0, MEM_WB_bubble 1); a branch held in EX is flushed in the ack cycle.
- MEM_TIMEOUT=3 and no ack for 5 cycles → o_mem_timeout=1 after the 3rd wait cycle and stays 1; reset clears it and both counters to 0.
- Reset asserted mid-freeze with i_MEM_req=0 at the reset edge → next cycle state RUN, all enables 1.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Stall/flush controller for the 5-stage RV32I pipeline. It handles the
// hazards that EX-stage forwarding cannot resolve:
//   - load-use: a load in EX whose rd is read by the instruction in ID
//   - taken branch/jump in EX: the two younger wrong-path instructions
//   - outstanding data-memory request: the whole pipeline freezes
// It also keeps stall/flush event counters and a sticky memory-timeout flag.
//
// Ports
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_ID_*                   instruction in ID and its decode attributes
//   i_EX_branch_taken        EX redirects the PC
//   i_MEM_req, i_MEM_ack     data-memory handshake of the MEM stage
//   o_*_en                   pipeline register enables
//   o_IF_ID_flush/ID_EX      insert a bubble at the next edge
//   o_MEM_WB_bubble          MEM/WB captures a bubble
//   o_stall_cnt/o_flush_cnt  load-use stall cycles / taken-branch flushes
//   o_mem_timeout            sticky: a memory wait reached MEM_TIMEOUT
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ID_inst,
    input  logic        i_ID_valid,
    input  logic        i_ID_rd_wren,
    input  logic        i_ID_is_load,
    input  logic        i_ID_uses_rs1,
    input  logic        i_ID_uses_rs2,
    input  logic        i_EX_branch_taken,
    input  logic        i_MEM_req,
    input  logic        i_MEM_ack,
    output logic        o_PC_en,
    output logic        o_IF_ID_en,
    output logic        o_ID_EX_en,
    output logic        o_EX_MEM_en,
    output logic        o_MEM_WB_en,
    output logic        o_IF_ID_flush,
    output logic        o_ID_EX_flush,
    output logic        o_MEM_WB_bubble,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt,
    output logic        o_mem_timeout
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               sh_v_q, sh_v_d;
    logic [4:0]         sh_rd_q, sh_rd_d;
    logic               sh_ld_q, sh_ld_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [31:0]        stall_cnt_q, stall_cnt_d;
    logic [31:0]        flush_cnt_q, flush_cnt_d;
    logic               timeout_q, timeout_d;

    logic [4:0]         id_rs1_s, id_rs2_s, id_rd_s;
    logic               fz_s, lu_s;
    logic               stall_inc_s, flush_inc_s;

    assign id_rs1_s = i_ID_inst[19:15];
    assign id_rs2_s = i_ID_inst[24:20];
    assign id_rd_s  = i_ID_inst[11:7];

    // Freeze is purely combinational so it also applies during reset.
    assign fz_s = i_MEM_req & ~i_MEM_ack;

    // Load-use: load in EX writing a non-zero rd that the ID instruction reads.
    assign lu_s = sh_v_q & sh_ld_q & (sh_rd_q != 5'd0) & i_ID_valid &
                  ((i_ID_uses_rs1 & (id_rs1_s == sh_rd_q)) |
                   (i_ID_uses_rs2 & (id_rs2_s == sh_rd_q)));

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (fz_s) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (i_MEM_ack) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_MEM_WAIT;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Pipeline control outputs, priority freeze > branch flush > load-use stall.
    always_comb begin
        o_PC_en         = 1'b1;
        o_IF_ID_en      = 1'b1;
        o_ID_EX_en      = 1'b1;
        o_EX_MEM_en     = 1'b1;
        o_MEM_WB_en     = 1'b1;
        o_IF_ID_flush   = 1'b0;
        o_ID_EX_flush   = 1'b0;
        o_MEM_WB_bubble = 1'b0;
        stall_inc_s     = 1'b0;
        flush_inc_s     = 1'b0;
        if (fz_s) begin
            // MEM/WB keeps clocking so the writeback stage drains a bubble.
            o_PC_en         = 1'b0;
            o_IF_ID_en      = 1'b0;
            o_ID_EX_en      = 1'b0;
            o_EX_MEM_en     = 1'b0;
            o_MEM_WB_bubble = 1'b1;
        end else if (i_EX_branch_taken) begin
            // ID holds a wrong-path instruction, so any load-use match is moot.
            o_IF_ID_flush = 1'b1;
            o_ID_EX_flush = 1'b1;
            flush_inc_s   = 1'b1;
        end else if (lu_s) begin
            o_PC_en       = 1'b0;
            o_IF_ID_en    = 1'b0;
            o_ID_EX_flush = 1'b1;
            stall_inc_s   = 1'b1;
        end else begin
            o_PC_en = 1'b1;
        end
    end

    // Next values of the EX shadow entry, wait counter and statistics.
    always_comb begin
        sh_v_d      = sh_v_q;
        sh_rd_d     = sh_rd_q;
        sh_ld_d     = sh_ld_q;
        wait_d      = wait_q;
        stall_cnt_d = stall_cnt_q + (stall_inc_s ? 32'd1 : 32'd0);
        flush_cnt_d = flush_cnt_q + (flush_inc_s ? 32'd1 : 32'd0);
        timeout_d   = timeout_q;

        // Shadow mirrors what the ID/EX register captures.
        if (o_ID_EX_en) begin
            if (o_ID_EX_flush) begin
                sh_v_d  = 1'b0;
                sh_rd_d = 5'd0;
                sh_ld_d = 1'b0;
            end else begin
                sh_v_d  = i_ID_valid & i_ID_rd_wren;
                sh_rd_d = id_rd_s;
                sh_ld_d = i_ID_is_load;
            end
        end else begin
            sh_v_d = sh_v_q;
        end

        if (state_q == ST_MEM_WAIT) begin
            if (wait_q == WAIT_MAX) begin
                wait_d = wait_q;
            end else begin
                wait_d = wait_q + WAIT_W'(1'b1);
            end
            if (wait_d == WAIT_MAX) begin
                timeout_d = 1'b1;
            end else begin
                timeout_d = timeout_q;
            end
        end else begin
            wait_d = '0;
        end
    end

    // Datapath registers: shadow entry, wait counter, counters, timeout flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sh_v_q      <= 1'b0;
            sh_rd_q     <= 5'd0;
            sh_ld_q     <= 1'b0;
            wait_q      <= '0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
            timeout_q   <= 1'b0;
        end else begin
            sh_v_q      <= sh_v_d;
            sh_rd_q     <= sh_rd_d;
            sh_ld_q     <= sh_ld_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_stall_cnt   = stall_cnt_q;
    assign o_flush_cnt   = flush_cnt_q;
    assign o_mem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//
// Directed-vector bench for hazard_ctrl_unit with MEM_TIMEOUT = 3. Inputs are
// driven on the falling edge and outputs are sampled 1 ns later, so registered
// values reflect every rising edge seen so far. Control outputs are packed as
// {PC, IF_ID, ID_EX, EX_MEM, MEM_WB enables, IF_ID flush, ID_EX flush, bubble}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] id_inst;
    logic        id_valid, id_rd_wren, id_is_load, id_u1, id_u2;
    logic        br, mem_req, mem_ack;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, mem_wb_bubble;
    logic [31:0] stall_cnt, flush_cnt;
    logic        mem_timeout;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [7:0] CTL_RUN    = 8'b11111_00_0;
    localparam logic [7:0] CTL_STALL  = 8'b00111_01_0;
    localparam logic [7:0] CTL_BRANCH = 8'b11111_11_0;
    localparam logic [7:0] CTL_FREEZE = 8'b00001_00_1;

    hazard_ctrl_unit #(.MEM_TIMEOUT(3)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_ID_inst         (id_inst),
        .i_ID_valid        (id_valid),
        .i_ID_rd_wren      (id_rd_wren),
        .i_ID_is_load      (id_is_load),
        .i_ID_uses_rs1     (id_u1),
        .i_ID_uses_rs2     (id_u2),
        .i_EX_branch_taken (br),
        .i_MEM_req         (mem_req),
        .i_MEM_ack         (mem_ack),
        .o_PC_en           (pc_en),
        .o_IF_ID_en        (if_id_en),
        .o_ID_EX_en        (id_ex_en),
        .o_EX_MEM_en       (ex_mem_en),
        .o_MEM_WB_en       (mem_wb_en),
        .o_IF_ID_flush     (if_id_flush),
        .o_ID_EX_flush     (id_ex_flush),
        .o_MEM_WB_bubble   (mem_wb_bubble),
        .o_stall_cnt       (stall_cnt),
        .o_flush_cnt       (flush_cnt),
        .o_mem_timeout     (mem_timeout)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] r_inst(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [7:0] ctl();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, mem_wb_bubble};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle.
    task automatic drive(input logic rst, input logic [31:0] inst, input logic v,
                         input logic wr, input logic ld, input logic u1, input logic u2,
                         input logic b, input logic req, input logic ack);
        @(negedge clk);
        rst_n      = rst;
        id_inst    = inst;
        id_valid   = v;
        id_rd_wren = wr;
        id_is_load = ld;
        id_u1      = u1;
        id_u2      = u2;
        br         = b;
        mem_req    = req;
        mem_ack    = ack;
        #1;
    endtask

    task automatic idle(input logic rst);
        drive(rst, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; id_inst = 32'd0; id_valid = 1'b0; id_rd_wren = 1'b0;
        id_is_load = 1'b0; id_u1 = 1'b0; id_u2 = 1'b0; br = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;

        // Reset state
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        check_eq("reset_ctl", {24'd0, ctl()}, {24'd0, CTL_RUN});
        check_eq("reset_stall_cnt", stall_cnt, 32'd0);
        check_eq("reset_flush_cnt", flush_cnt, 32'd0);
        check_eq("reset_timeout", {31'd0, mem_timeout}, 32'd0);

        // Load x5 then add x6,x5,x1: one stall cycle
        drive(1'b1, r_inst(5'd5, 5'd1, 5'd0), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("lw_issue_ctl", {24'd0, ctl()}, {24'd0, CTL_RUN});
        drive(1'b1, r_inst(5'd6, 5'd5, 5'd1), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("lu_stall_ctl", {24'd0, ctl()}, {24'd0, CTL_STALL});
        drive(1'b1, r_inst(5'd6, 5'd5, 5'd1), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("lu_release_ctl", {24'd0, ctl()}, {24'd0, CTL_RUN});
        check_eq("lu_stall_cnt", stall_cnt, 32'd1);

        // Load to x0 then reader of x0: no stall
        drive(1'b1, r_inst(5'd0, 5'd1, 5'd0), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, r_inst(5'd7, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("x0_no_stall_ctl", {24'd0, ctl()}, {24'd0, CTL_RUN});

        // Load x5 then rs2=5 with uses_rs2=0: no stall
        drive(1'b1, r_inst(5'd5, 5'd1, 5'd0), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, r_inst(5'd8, 5'd1, 5'd5), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rs2_unused_ctl", {24'd0, ctl()}, {24'd0, CTL_RUN});

        // Load x5 then matching consumer that is not valid: no stall
        drive(1'b1, r_inst(5'd5, 5'd1, 5'd0), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, r_inst(5'd6, 5'd5, 5'd1), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("id_invalid_ctl", {24'd0, ctl()}, {24'd0, CTL_RUN});
        check_eq("no_extra_stall_cnt", stall_cnt, 32'd1);

        // Branch taken while load-use also true: flush wins
        drive(1'b1, r_inst(5'd5, 5'd1, 5'd0), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, r_inst(5'd6, 5'd5, 5'd1), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("br_over_lu_ctl", {24'd0, ctl()}, {24'd0, CTL_BRANCH});
        idle(1'b1);
        check_eq("br_flush_cnt", flush_cnt, 32'd1);
        check_eq("br_stall_cnt", stall_cnt, 32'd1);
        check_eq("br_after_ctl", {24'd0, ctl()}, {24'd0, CTL_RUN});

        // Memory request acked in the 4th cycle, branch pending in EX
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            check_eq($sformatf("freeze_ctl_%0d", i), {24'd0, ctl()}, {24'd0, CTL_FREEZE});
        end
        check_eq("freeze_flush_cnt_hold", flush_cnt, 32'd1);
        drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("ack_branch_ctl", {24'd0, ctl()}, {24'd0, CTL_BRANCH});
        idle(1'b1);
        check_eq("ack_flush_cnt", flush_cnt, 32'd2);
        check_eq("ack_after_ctl", {24'd0, ctl()}, {24'd0, CTL_RUN});

        // Reset asserted mid-freeze
        drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("rst_req_freeze_ctl", {24'd0, ctl()}, {24'd0, CTL_FREEZE});
        idle(1'b0);
        check_eq("rst_noreq_ctl", {24'd0, ctl()}, {24'd0, CTL_RUN});
        idle(1'b1);
        check_eq("rst_mid_ctl", {24'd0, ctl()}, {24'd0, CTL_RUN});
        check_eq("rst_mid_flush_cnt", flush_cnt, 32'd0);
        check_eq("rst_mid_stall_cnt", stall_cnt, 32'd0);
        check_eq("rst_mid_timeout", {31'd0, mem_timeout}, 32'd0);
        // If the FSM had stayed in MEM_WAIT, these idle cycles would time out.
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
        end
        check_eq("rst_mid_run_state", {31'd0, mem_timeout}, 32'd0);

        // Timeout: no ack for 5 cycles with MEM_TIMEOUT=3
        drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            check_eq($sformatf("to_pending_%0d", i), {31'd0, mem_timeout}, 32'd0);
        end
        drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("to_set", {31'd0, mem_timeout}, 32'd1);
        check_eq("to_still_frozen", {24'd0, ctl()}, {24'd0, CTL_FREEZE});
        drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("to_ack_ctl", {24'd0, ctl()}, {24'd0, CTL_RUN});
        idle(1'b1);
        idle(1'b1);
        check_eq("to_sticky", {31'd0, mem_timeout}, 32'd1);
        idle(1'b0);
        idle(1'b1);
        check_eq("to_reset_clear", {31'd0, mem_timeout}, 32'd0);
        check_eq("to_reset_flush_cnt", flush_cnt, 32'd0);
        check_eq("to_reset_stall_cnt", stall_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
